ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, e.g. 0xED set-LEDs and 0xF4 enable, over the same ps2_clk/ps2_data pair that ps2_keyboard receives on.
- Runs the inhibit / request-to-send sequence, shifts the frame out on device-generated clock edges, and checks the device ACK.
- Drives the bus open-drain through active-high pull-low enables. Pad logic outside this block does the tristating.
- Sits beside ps2_keyboard in the SoC top; tx_busy lets the top hold the receiver cleared during a transmit.

Parameters:
- INHIBIT_CYCLES, default 5000: clk cycles the host holds ps2_clk low (100 us at 50 MHz).
- TIMEOUT_CYCLES, default 750000: maximum clk cycles allowed between device clock falling edges, and for the final bus release (15 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- clrn  in  1  asynchronous, active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; a byte is accepted when tx_valid && tx_ready.
- tx_busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse at the end of every transfer.
- tx_ack  out  1  valid with tx_done: 1 = device ACK seen.
- tx_err  out  1  valid with tx_done: 1 = timeout or missing ACK.
- ps2_clk  in  1  raw bus clock, asynchronous.
- ps2_data  in  1  raw bus data, asynchronous.
- ps2_clk_oe  out  1  1 = pull ps2_clk low.
- ps2_data_oe  out  1  1 = pull ps2_data low.

Behaviour:
- Reset (clrn low, asynchronous):
  - State goes to IDLE immediately.
  - ps2_clk_oe = 0, ps2_data_oe = 0, tx_done/tx_ack/tx_err = 0, tx_busy = 0, tx_ready = 1.
  - The shift register, bit counter, timers and synchronizer flops are all cleared (synchronizer flops to 1).
  - Reset mid-frame releases both lines with no completion pulse.
- Input synchronizer and edge detect:
  - ps2_clk and ps2_data pass through a 3-flop synchronizer (reset value 1).
  - A falling edge is sync[2:1] == 2'b10, giving a 2-3 cycle latency.
  - Edges are ignored in INHIBIT and REQ, where the host is driving the clock itself.
- Parity: odd, computed as ~^tx_data and latched at accept.
- IDLE:
  - tx_ready = 1.
  - On accept, latch the byte and move to INHIBIT on the next cycle.
  - tx_valid while not in IDLE is ignored.
- INHIBIT: ps2_clk_oe = 1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ: ps2_clk_oe = 1 and ps2_data_oe = 1 for 1 cycle (start bit placed), then go to XFER.
- XFER:
  - ps2_clk_oe = 0 (clock released); bit counter n runs 0..9, advancing on each device falling edge.
  - ps2_data_oe = ~bit(n), where bits 0-7 = tx_data LSB first, bit 8 = parity, bit 9 = stop (1, data released).
  - Before the 1st edge, data_oe stays 1 (start bit).
  - Bit n is presented on the 1st cycle after edge n+1 is detected.
  - After the 10th edge (stop presented), go to ACK.
- ACK:
  - Both oe = 0.
  - On the 11th falling edge, sample synchronized ps2_data: 0 = ACK, 1 = NACK (record error).
  - Then go to RELEASE.
- RELEASE:
  - Wait until synchronized ps2_clk and ps2_data are both 1.
  - Then pulse tx_done, with tx_ack = ~err and tx_err = err, and return to IDLE.
  - In IDLE, tx_ready is high again on the cycle after the tx_done pulse.
- Timeout:
  - In XFER, ACK and RELEASE, a counter is cleared on every detected falling edge and on state entry.
  - When it reaches TIMEOUT_CYCLES: release both lines, pulse tx_done with tx_ack = 0 and tx_err = 1, and return to IDLE.
- If the device is mid-transmit when a request arrives, the host inhibit takes priority. The device aborts; no special handling is needed here.
- tx_ack/tx_err hold their values until the next accept; they are meaningful only while tx_done is high.

Decomposition:
- Package ps2_pkg holds:
  - state encodings IDLE / INHIBIT / REQ / XFER / ACK / RELEASE;
  - PS2_FRAME_EDGES = 11;
  - PS2 command constants PS2_CMD_SET_LED = 8'hED, PS2_CMD_ENABLE = 8'hF4, PS2_ACK_BYTE = 8'hFA.
- One sub-module: ps2_edge_sync, the 3-flop synchronizer plus falling-edge pulse, reusable by ps2_keyboard.
- The timer widths are $clog2 of the parameters.

Test Plan:
Bench uses INHIBIT_CYCLES = 8, TIMEOUT_CYCLES = 200, and a device model clocking at a 20-cycle period.
- Send 0xED with the device ACKing:
  - clk_oe is high exactly 8 cycles, then 1 REQ cycle with both oe high.
  - Device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once with tx_ack = 1, tx_err = 0.
  - tx_busy is high from the cycle after accept until tx_done.
- Send 0xF4 with the device ACKing: device samples bits 0,0,1,0,1,1,1,1, parity 0; tx_ack = 1.
- Device gives NACK (ps2_data high at the 11th edge): tx_done with tx_ack = 0, tx_err = 1; both oe are 0 afterwards.
- Device stops clocking after 4 edges: exactly 200 cycles after the 4th detected edge, tx_done with tx_err = 1, oe = 0, state IDLE, tx_ready = 1.
- clrn pulsed low during XFER bit 5: on the same edge both oe drop to 0 and tx_busy = 0, with no tx_done. A new 0x00 request then completes with parity 1.
- tx_valid held high through a transfer with tx_data changed mid-frame: the transmitted byte is the value latched at accept, and exactly one transfer occurs per accept.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, frame layout and
// common keyboard command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_XFER,
    ST_ACK,
    ST_RELEASE
  } ps2_tx_state_e;

  localparam int unsigned PS2_FRAME_EDGES = 11;
  // Bits the host shifts out after the start bit: 8 data, parity, stop.
  localparam int unsigned PS2_TX_BITS     = PS2_FRAME_EDGES - 1;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
  } ps2_tx_frame_t;

  // Frame as shifted LSB first: data[0..7], odd parity, stop.
  function automatic ps2_tx_frame_t ps2_make_frame(input logic [7:0] d);
    ps2_tx_frame_t f;
    f.stop   = 1'b1;
    f.parity = ~^d;
    f.data   = d;
    return f;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Three-flop synchronizer for the raw PS/2 clock and data lines plus a
// falling-edge pulse on the clock; shared with the keyboard receiver.
module ps2_edge_sync (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall_c
);

  logic [2:0] clk_sync_q;
  logic [2:0] data_sync_q;

  // Idle bus is high, so reset the chains to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 3'b111;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[1:0], ps2_data};
    end
  end

  assign clk_s      = clk_sync_q[2];
  assign data_s     = data_sync_q[2];
  assign clk_fall_c = (clk_sync_q[2:1] == 2'b10);

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift out the
// frame on device clock edges, check ACK, wait for bus release.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ack,
  output logic       tx_err,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned BIT_W = $clog2(PS2_TX_BITS);

  ps2_tx_state_e  state;
  ps2_tx_frame_t  frame_q;
  logic [BIT_W-1:0] bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             err_q;

  logic clk_s;
  logic data_s;
  logic clk_fall_c;
  logic timing_c;
  logic to_hit_c;

  ps2_edge_sync u_sync (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .clk_s      (clk_s),
    .data_s     (data_s),
    .clk_fall_c (clk_fall_c)
  );

  // Device-clocked states are guarded by the inter-edge timeout.
  assign timing_c = (state == ST_XFER) || (state == ST_ACK) || (state == ST_RELEASE);
  assign to_hit_c = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= ST_IDLE;
      frame_q     <= '0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      err_q       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_ack      <= 1'b0;
      tx_err      <= 1'b0;
      tx_busy     <= 1'b0;
      tx_ready    <= 1'b1;
    end else begin
      tx_done <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            frame_q    <= ps2_make_frame(tx_data);
            err_q      <= 1'b0;
            tx_ack     <= 1'b0;
            tx_err     <= 1'b0;
            inh_cnt    <= '0;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
            ps2_clk_oe <= 1'b1;
            state      <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            ps2_data_oe <= 1'b1;
            state       <= ST_REQ;
          end else begin
            inh_cnt <= inh_cnt + INH_W'(1);
          end
        end

        // Start bit is on the bus; hand the clock to the device.
        ST_REQ: begin
          ps2_clk_oe <= 1'b0;
          bit_cnt    <= '0;
          to_cnt     <= '0;
          state      <= ST_XFER;
        end

        ST_XFER: begin
          if (clk_fall_c) begin
            ps2_data_oe <= ~frame_q[bit_cnt];
            if (bit_cnt == BIT_W'(PS2_TX_BITS - 1)) begin
              state <= ST_ACK;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end

        ST_ACK: begin
          ps2_data_oe <= 1'b0;
          if (clk_fall_c) begin
            err_q <= data_s;
            state <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (clk_s && data_s) begin
            tx_done <= 1'b1;
            tx_ack  <= ~err_q;
            tx_err  <= err_q;
            tx_busy <= 1'b0;
            state   <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase

      // Inter-edge watchdog; an expiry overrides whatever the state did.
      if (timing_c) begin
        if (clk_fall_c) begin
          to_cnt <= '0;
        end else if (to_hit_c) begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx_done     <= 1'b1;
          tx_ack      <= 1'b0;
          tx_err      <= 1'b1;
          tx_busy     <= 1'b0;
          state       <= ST_IDLE;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a simple
// device model clocking at a 20-cycle period.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH = 8;
  localparam int unsigned TO  = 200;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_ack, tx_err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int busy_gap = 0;
  bit mon_busy = 1'b0;
  logic last_ack = 1'b0, last_err = 1'b0, last_clk_oe = 1'b0, last_data_oe = 1'b0;

  assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_line = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_ack      (tx_ack),
    .tx_err      (tx_err),
    .ps2_clk     (ps2_clk_line),
    .ps2_data    (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (tx_done) begin
        done_cnt++;
        mon_busy     = 1'b0;
        last_ack     = tx_ack;
        last_err     = tx_err;
        last_clk_oe  = ps2_clk_oe;
        last_data_oe = ps2_data_oe;
      end else if (mon_busy && !tx_busy) begin
        busy_gap++;
      end
    end
  endtask

  task automatic request(input string nm, input logic [7:0] d, input bit hold);
    int g;
    g = 0;
    while (!tx_ready && g < 20) begin
      tick(1);
      g++;
    end
    check({nm, "_ready"}, 32'(tx_ready), 1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    if (!hold) tx_valid = 1'b0;
    mon_busy = 1'b1;
    busy_gap = 0;
    check({nm, "_accept_busy_ready_oe"}, {tx_busy, tx_ready, ps2_clk_oe, ps2_data_oe}, 4'b1010);
  endtask

  // Called on the first INHIBIT cycle; measures inhibit and request phases.
  task automatic host_rts(input string nm);
    int inh, req, g;
    inh = 0; req = 0; g = 0;
    while (ps2_clk_oe && !ps2_data_oe && g < 100) begin inh++; g++; tick(1); end
    while (ps2_clk_oe && ps2_data_oe && g < 100) begin req++; g++; tick(1); end
    check({nm, "_inhibit_cycles"}, 32'(inh), 8);
    check({nm, "_req_cycles"}, 32'(req), 1);
    check({nm, "_start_bit_oe"}, {ps2_clk_oe, ps2_data_oe}, 2'b01);
  endtask

  // Device clocks n bits, sampling the bus while its clock is low.
  task automatic dev_edges(input int n, output logic [9:0] bits);
    bits = '0;
    tick(5);
    for (int i = 0; i < n; i++) begin
      dev_clk = 1'b0;
      tick(10);
      bits[i] = ps2_data_line;
      dev_clk = 1'b1;
      tick(10);
    end
  endtask

  task automatic finish_frame(input string nm, input logic [9:0] exp_bits, input logic nack);
    logic [9:0] bits;
    int d0, cyc;
    host_rts(nm);
    dev_edges(10, bits);
    check({nm, "_frame_bits"}, 32'(bits), 32'(exp_bits));
    dev_data = nack;
    tick(5);
    dev_clk = 1'b0;
    tick(10);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    d0 = done_cnt;
    cyc = 0;
    while (done_cnt == d0 && cyc < 50) begin tick(1); cyc++; end
    check({nm, "_done_seen"}, 32'(done_cnt - d0), 1);
    check({nm, "_ack_err"}, {last_ack, last_err}, {~nack, nack});
    check({nm, "_done_oe"}, {last_clk_oe, last_data_oe}, 2'b00);
    check({nm, "_busy_gap"}, 32'(busy_gap), 0);
    tick(1);
    check({nm, "_single_pulse"}, 32'(done_cnt - d0), 1);
    check({nm, "_after_busy_ready"}, {tx_busy, tx_ready}, 2'b01);
  endtask

  initial begin
    logic [9:0] bits;
    int cyc, d0;

    #1 clrn = 1'b0;
    tick(3);
    check("reset_outputs", {tx_ready, tx_busy, tx_done, tx_ack, tx_err, ps2_clk_oe, ps2_data_oe},
          7'b1000000);
    clrn = 1'b1;
    tick(3);

    // 0xED: LSB first 1,0,1,1,0,1,1,1, parity 1, stop 1.
    request("set_led", PS2_CMD_SET_LED, 1'b0);
    finish_frame("set_led", 10'b11_1110_1101, 1'b0);

    // 0xF4: 0,0,1,0,1,1,1,1, parity 0, stop 1.
    request("enable", PS2_CMD_ENABLE, 1'b0);
    finish_frame("enable", 10'b10_1111_0100, 1'b0);

    // Device holds data high on the 11th edge.
    request("nack", PS2_CMD_ENABLE, 1'b0);
    finish_frame("nack", 10'b10_1111_0100, 1'b1);
    check("nack_idle_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    // Device stops after 4 edges: edge seen 3 clocks after the drive, then 200.
    request("timeout", PS2_CMD_ENABLE, 1'b0);
    host_rts("timeout");
    dev_edges(3, bits);
    check("timeout_first_bits", 32'(bits[2:0]), 3'b100);
    dev_clk = 1'b0;
    d0 = done_cnt;
    cyc = 0;
    while (done_cnt == d0 && cyc < 400) begin tick(1); cyc++; end
    check("timeout_latency", 32'(cyc), 203);
    check("timeout_ack_err", {last_ack, last_err}, 2'b01);
    check("timeout_oe", {last_clk_oe, last_data_oe}, 2'b00);
    tick(1);
    check("timeout_idle_ready_busy", {tx_ready, tx_busy}, 2'b10);
    dev_clk = 1'b1;
    tick(5);

    // Reset while bit 5 of 0x12 (a 0, so data pulled low) is on the bus.
    request("abort", 8'h12, 1'b0);
    host_rts("abort");
    dev_edges(5, bits);
    check("abort_first_bits", 32'(bits[4:0]), 5'b10010);
    dev_clk = 1'b0;
    tick(6);
    check("abort_bit5_oe_busy", {ps2_clk_oe, ps2_data_oe, tx_busy}, 3'b011);
    d0 = done_cnt;
    #3 clrn = 1'b0;
    #1;
    check("abort_async_outputs", {ps2_clk_oe, ps2_data_oe, tx_busy, tx_ready, tx_done}, 5'b00010);
    mon_busy = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    #2 clrn = 1'b1;
    tick(5);
    check("abort_no_done", 32'(done_cnt - d0), 0);

    // 0x00 after the abort: parity 1, stop 1.
    request("zero", 8'h00, 1'b0);
    finish_frame("zero", 10'b11_0000_0000, 1'b0);

    // tx_valid held, data changed after accept: frame uses the latched byte.
    d0 = done_cnt;
    request("hold", PS2_CMD_ENABLE, 1'b1);
    tx_data = PS2_CMD_SET_LED;
    finish_frame("hold", 10'b10_1111_0100, 1'b0);
    tick(1);
    tx_valid = 1'b0;
    mon_busy = 1'b1;
    busy_gap = 0;
    check("hold_reaccept", {tx_busy, tx_ready, ps2_clk_oe}, 3'b101);
    finish_frame("hold2", 10'b11_1110_1101, 1'b0);
    tick(30);
    check("hold_transfer_count", 32'(done_cnt - d0), 2);
    check("hold_final_idle", {tx_busy, tx_ready, ps2_clk_oe}, 3'b010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
